adc3664_spi_read_responder: RTL
===============================

# adc3664_spi_read_responder

Slave-side read responder for the ADC3664 3-wire SPI register interface: decodes the 24-bit frame header on SCLK rising edges, fetches the addressed register from the register file, and shifts the 8-bit value out on SDIO on falling edges. It sits beside the write-capture slave, shares the SEN/SCLK/SDIO pins with it, and owns the SDIO output-enable. Write frames are decoded and ignored.

## Interface
- ADDR_W, 12, register address width
- DATA_W, 8, register data width
- HDR_W, 16, header length in bits (R/W flag + reserved + address)
- SCLK  in  1  SPI clock; sample on rising edge, drive on falling edge
- Reset  in  1  asynchronous, active-high reset
- SEN  in  1  frame enable, active low; high acts as asynchronous frame clear
- sdio_in  in  1  SDIO pad input
- sdio_out  out  1  SDIO pad output data
- sdio_oe  out  1  SDIO pad output enable, 1 = drive
- reg_addr  out  ADDR_W  register-file read address
- reg_rd_en  out  1  register-file read strobe
- reg_rd_data  in  DATA_W  register-file read data, combinational from reg_addr
- rd_done  out  1  read frame fully shifted out

## Operation
- Frame: 24 bits, MSB first. Header bit 15 = R/W (1 = read), bits 14:12 reserved (ignored), bits 11:0 = address; then 8 data bits.
- Bit counter bit_cnt (5 bits) counts rising SCLK edges while SEN low; saturates at 24; extra edges ignored.
- States (rising-edge domain): IDLE (bit_cnt 0) -> HEADER (rises 1..15) -> at rise 16: READ if {hdr[14:0],sdio_in}[15]=1 else WRITE -> DONE at rise 24. DONE holds until SEN high.
- At rise 16: reg_addr <= {hdr[14:0],sdio_in}[11:0] for both R/W (holds afterwards); reg_rd_en <= 1 only for READ; reg_rd_en <= 0 at rise 17.
- Falling-edge domain (tx shifter), READ only: at fall following rise 16, load tx_shift <= reg_rd_data, sdio_out <= reg_rd_data[7], sdio_oe <= 1; falls after rises 17..23 drive bits 6..0; fall after rise 24: sdio_oe <= 0, sdio_out <= 0, rd_done <= 1.
- WRITE frames: sdio_oe stays 0, rd_done stays 0, data bits ignored.
- SEN high (any time, async): clear bit_cnt, state to IDLE, header shift, reg_rd_en, sdio_oe, sdio_out, tx_shift, rd_done. reg_addr holds.
- Reset (async): all of the above plus reg_addr <= 0.
- Reset values: sdio_out 0, sdio_oe 0, reg_addr 0, reg_rd_en 0, rd_done 0.

## Timing
- Header-to-data turnaround: half SCLK period; reg_rd_data must settle between rise 16 and the following fall.
- Master samples data bits 7..0 on rises 17..24; each bit stable a full SCLK period from the preceding fall.
- sdio_oe high exactly 8 SCLK periods (fall 16 to fall 24).
- rd_done high from fall 24 until SEN high or Reset.
- SEN rises mid-read (e.g. after rise 20): sdio_oe drops immediately, no further drive; next frame starts clean at bit_cnt 0.
- SEN low with no SCLK: no output change.
- Reset mid-frame overrides SEN and SCLK.

## Structure
- Shared package adc3664_spi_pkg: FRAME_W=24, HDR_W, ADDR_W, DATA_W, RW_BIT=15, state enum {IDLE, HEADER, READ, WRITE, DONE}.
- One sub-module: adc3664_spi_tx_shifter (negedge load/shift, sdio_out, sdio_oe, rd_done; inputs load, frame_clr, Reset).
- Top holds rising-edge counter, header shift and state machine.

## Test plan
- Read addr 0x0A5, reg file 0x0A5=0x3C: header 0x80A5 -> reg_addr=0x0A5, reg_rd_en one period after rise 16, SDIO = 0,0,1,1,1,1,0,0 at rises 17..24, rd_done=1 after fall 24.
- Write header 0x0123 data 0xFF -> sdio_oe never 1, rd_done 0, reg_rd_en 0, reg_addr=0x123.
- Read 0xFFF with 0xA5, SEN raised after rise 20 -> sdio_oe 0 immediately, rd_done 0; following read of 0x001 (=0x5A) returns 0x5A correctly.
- Read 0x010 (=0x81) with 30 SCLKs -> bits 1,0,0,0,0,0,0,1 then sdio_oe 0 for rises 25..30, bit_cnt stays 24.
- Reset asserted at rise 18 of a read -> all outputs 0 incl. reg_addr, no drive until next full frame.
- Reserved bits set (header 0xF0A5) -> treated as read of 0x0A5.

Source files
------------

// File: rtl/adc3664_spi_pkg.sv
// Shared constants and state encoding for the ADC3664 3-wire SPI register slave.
package adc3664_spi_pkg;
  localparam int FRAME_W = 24;
  localparam int HDR_W   = 16;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int RW_BIT  = 15;
  localparam int CNT_W   = 5;

  localparam logic [CNT_W-1:0] CNT_HDR      = CNT_W'(HDR_W);
  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {IDLE, HEADER, READ, WRITE, DONE} state_e;
endpackage

// File: rtl/adc3664_spi_read_responder_if.sv
// SPI pin and register-file read signals seen by the read responder.
interface adc3664_spi_read_responder_if;
  logic                               SEN;
  logic                               sdio_in;
  logic                               sdio_out;
  logic                               sdio_oe;
  logic [adc3664_spi_pkg::ADDR_W-1:0] reg_addr;
  logic                               reg_rd_en;
  logic [adc3664_spi_pkg::DATA_W-1:0] reg_rd_data;
  logic                               rd_done;

  modport master (
    output SEN, sdio_in, reg_rd_data,
    input  sdio_out, sdio_oe, reg_addr, reg_rd_en, rd_done
  );

  modport slave (
    input  SEN, sdio_in, reg_rd_data,
    output sdio_out, sdio_oe, reg_addr, reg_rd_en, rd_done
  );
endinterface

// File: rtl/adc3664_spi_tx_shifter.sv
// Falling-edge SDIO driver: loads the read byte, shifts it out MSB first,
// then releases the pad and flags completion.
module adc3664_spi_tx_shifter
  import adc3664_spi_pkg::*;
(
  input  logic              SCLK,
  input  logic              Reset,
  input  logic              frame_clr_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              finish_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              sdio_out_o,
  output logic              sdio_oe_o,
  output logic              rd_done_o
);

  // Only the bits still to be sent are kept; the MSB goes straight to the pad.
  logic [DATA_W-2:0] tx_shift_q, tx_shift_d;
  logic              sdio_out_q, sdio_out_d;
  logic              sdio_oe_q, sdio_oe_d;
  logic              rd_done_q, rd_done_d;

  always_comb begin
    tx_shift_d = tx_shift_q;
    sdio_out_d = sdio_out_q;
    sdio_oe_d  = sdio_oe_q;
    rd_done_d  = rd_done_q;
    if (load_i) begin
      tx_shift_d = data_i[DATA_W-2:0];
      sdio_out_d = data_i[DATA_W-1];
      sdio_oe_d  = 1'b1;
    end else if (shift_i) begin
      tx_shift_d = {tx_shift_q[DATA_W-3:0], 1'b0};
      sdio_out_d = tx_shift_q[DATA_W-2];
    end else if (finish_i && sdio_oe_q) begin
      sdio_oe_d  = 1'b0;
      sdio_out_d = 1'b0;
      rd_done_d  = 1'b1;
    end
  end

  always_ff @(negedge SCLK or posedge Reset or posedge frame_clr_i) begin
    if (Reset || frame_clr_i) begin
      tx_shift_q <= '0;
      sdio_out_q <= 1'b0;
      sdio_oe_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      sdio_out_q <= sdio_out_d;
      sdio_oe_q  <= sdio_oe_d;
      rd_done_q  <= rd_done_d;
    end
  end

  assign sdio_out_o = sdio_out_q;
  assign sdio_oe_o  = sdio_oe_q;
  assign rd_done_o  = rd_done_q;

endmodule

// File: rtl/adc3664_spi_read_responder.sv
// ADC3664 SPI read responder: rising-edge header decode and register fetch,
// with the falling-edge data shifter owning the SDIO output enable.
module adc3664_spi_read_responder
  import adc3664_spi_pkg::*;
(
  input logic                         SCLK,
  input logic                         Reset,
  adc3664_spi_read_responder_if.slave bus
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [HDR_W-2:0]    hdr_q, hdr_d;
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic                rd_en_q, rd_en_d;
  logic [HDR_W-1:0]    hdr_full;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    hdr_d      = hdr_q;
    reg_addr_d = reg_addr_q;
    rd_en_d    = 1'b0;
    // Header as it stands including the bit being sampled on this edge.
    hdr_full   = {hdr_q, bus.sdio_in};

    if (bit_cnt_q < CNT_FULL) bit_cnt_d = bit_cnt_q + 1'b1;
    if (bit_cnt_q < CNT_HDR)  hdr_d     = hdr_full[HDR_W-2:0];

    case (state_q)
      IDLE:   state_d = HEADER;
      HEADER: begin
        if (bit_cnt_q == CNT_HDR_LAST) begin
          reg_addr_d = hdr_full[ADDR_W-1:0];
          if (hdr_full[RW_BIT]) begin
            state_d = READ;
            rd_en_d = 1'b1;
          end else begin
            state_d = WRITE;
          end
        end
      end
      READ, WRITE: if (bit_cnt_q == CNT_LAST) state_d = DONE;
      DONE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // SEN high clears the frame but the last decoded address is kept.
  always_ff @(posedge SCLK or posedge Reset or posedge bus.SEN) begin
    if (Reset || bus.SEN) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      hdr_q     <= '0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      hdr_q     <= hdr_d;
      rd_en_q   <= rd_en_d;
    end
  end

  always_ff @(posedge SCLK or posedge Reset) begin
    if (Reset) reg_addr_q <= '0;
    else       reg_addr_q <= reg_addr_d;
  end

  adc3664_spi_tx_shifter u_tx (
    .SCLK        (SCLK),
    .Reset       (Reset),
    .frame_clr_i (bus.SEN),
    .load_i      ((state_q == READ) && (bit_cnt_q == CNT_HDR)),
    .shift_i     ((state_q == READ) && (bit_cnt_q > CNT_HDR)),
    .finish_i    (state_q == DONE),
    .data_i      (bus.reg_rd_data),
    .sdio_out_o  (bus.sdio_out),
    .sdio_oe_o   (bus.sdio_oe),
    .rd_done_o   (bus.rd_done)
  );

  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_rd_en = rd_en_q;

endmodule
